// File: rtl/r22sdf_frame_ctrl.sv
// r22sdf_frame_ctrl
//   Frame sequencer for an enable-gated R22SDF FFT pipeline. Upstream samples
//   enter through a valid/ready handshake. Each accepted sample pulses the
//   pipeline's global enable (core_en), and only while the twiddle CORDICs
//   report ready. Samples are counted into frames of FFT_LEN. After the last
//   frame the controller flushes the pipeline by itself. Pipeline output is
//   tagged with valid/sop/eop and with the natural-order bin index of each
//   bit-reversed result.
//
// Handshake: a sample transfers on every rising sys_clk edge where
//   in_valid & in_ready. in_ready depends only on state, cordic_rdy and
//   abort, never on in_valid.
//
// Ports
//   sys_clk, sys_nrst    clock, asynchronous active-low reset
//   abort                synchronous soft clear (keeps the CORDIC wait)
//   cordic_rdy           AND of all twiddle generator ready flags
//   in_valid / in_ready  upstream sample handshake
//   core_en              global pipeline enable (combinational)
//   out_valid/sop/eop    tags for pipeline dout sampled at the same edge
//   out_idx              natural-order bin index of the current output
//   frame_done           completed output frames, wraps at 16 bits
//   busy                 controller is in RUN or FLUSH
//   dbg_state, dbg_pend  FSM state and in-flight sample count, for observation
module r22sdf_frame_ctrl #(
  parameter int FFT_LEN    = 1024,
  parameter int PIPE_LAT   = 1100,
  parameter int FLUSH_WAIT = 16,
  localparam int IW = $clog2(FFT_LEN),
  localparam int CW = $clog2(PIPE_LAT + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_nrst,
  input  logic          abort,
  input  logic          cordic_rdy,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          core_en,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic [IW-1:0] out_idx,
  output logic [15:0]   frame_done,
  output logic          busy,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_pend
);

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    RUN      = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] in_cnt;
  logic [IW-1:0] out_cnt;
  logic [CW-1:0] en_cnt;
  logic [CW-1:0] pend;
  logic [7:0]    idle_cnt;
  logic [IW-1:0] out_cnt_rev;
  logic          accept;
  logic          idle_done;

  // abort masks the handshake in its own cycle. Otherwise a sample could be
  // accepted and then thrown away by the clear.
  assign in_ready  = cordic_rdy & ~abort & ((state == IDLE) | (state == RUN));
  assign accept    = in_valid & in_ready;
  assign core_en   = cordic_rdy & ~abort & (accept | (state == FLUSH));

  // A result is real once the pipeline has been primed PIPE_LAT times since
  // it last held only bubbles, and a real sample is still inside.
  assign out_valid = core_en & (en_cnt >= CW'(PIPE_LAT)) & (pend != '0);
  assign out_sop   = out_valid & (out_cnt == '0);
  assign out_eop   = out_valid & (out_cnt == IW'(FFT_LEN - 1));
  assign out_idx   = out_valid ? out_cnt_rev : '0;

  // WAIT_RDY counts as not busy, which keeps busy low out of reset.
  assign busy      = (state == RUN) | (state == FLUSH);
  assign dbg_state = state;
  assign dbg_pend  = pend;
  assign idle_done = (idle_cnt == 8'(FLUSH_WAIT - 1));

  always_comb begin
    out_cnt_rev = '0;
    for (int i = 0; i < IW; i++) out_cnt_rev[i] = out_cnt[IW-1-i];
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state      <= WAIT_RDY;
      in_cnt     <= '0;
      out_cnt    <= '0;
      en_cnt     <= '0;
      pend       <= '0;
      idle_cnt   <= '0;
      frame_done <= '0;
    end else if (abort) begin
      // Restarting en_cnt means stale pipeline contents are never tagged.
      state      <= cordic_rdy ? IDLE : WAIT_RDY;
      in_cnt     <= '0;
      out_cnt    <= '0;
      en_cnt     <= '0;
      pend       <= '0;
      idle_cnt   <= '0;
      frame_done <= '0;
    end else begin
      if (core_en) begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (en_cnt != CW'(PIPE_LAT)) en_cnt <= en_cnt + 1'b1;
        case ({accept, out_valid})
          2'b10:   pend <= pend + 1'b1;
          2'b01:   pend <= pend - 1'b1;
          default: pend <= pend;
        endcase
        if (out_valid) begin
          out_cnt <= out_cnt + 1'b1;
          if (out_eop) frame_done <= frame_done + 16'd1;
        end
      end

      case (state)
        WAIT_RDY: if (cordic_rdy) state <= IDLE;
        IDLE:     if (accept) state <= RUN;
        RUN: begin
          // Idle time is counted only at a frame boundary. A partial frame
          // waits for more samples indefinitely.
          if (cordic_rdy) begin
            if (accept || (in_cnt != '0)) begin
              idle_cnt <= '0;
            end else if (idle_done) begin
              idle_cnt <= '0;
              state    <= FLUSH;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        FLUSH: begin
          // Leave as the last real sample exits. The pipeline then holds only
          // bubbles, so priming restarts for the next frame.
          if (cordic_rdy && ((pend == '0) || (out_valid && (pend == CW'(1))))) begin
            state  <= IDLE;
            en_cnt <= '0;
          end
        end
        default: state <= WAIT_RDY;
      endcase
    end
  end

endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Directed bench for r22sdf_frame_ctrl with FFT_LEN=16, PIPE_LAT=20 and
// FLUSH_WAIT=16. Inputs change 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
module tb_r22sdf_frame_ctrl;
  localparam int FL = 16;
  localparam int PL = 20;
  localparam int FW = 16;
  localparam int CW = $clog2(PL + 1);
  localparam logic [1:0] S_WAIT = 2'd0, S_IDLE = 2'd1, S_RUN = 2'd2, S_FLUSH = 2'd3;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_nrst = 1'b0;
  logic abort = 1'b0;
  logic cordic_rdy = 1'b0;
  logic in_valid = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          in_ready, core_en, out_valid, out_sop, out_eop, busy;
  logic [3:0]    out_idx;
  logic [15:0]   frame_done;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_pend;

  r22sdf_frame_ctrl #(.FFT_LEN(FL), .PIPE_LAT(PL), .FLUSH_WAIT(FW)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .abort(abort), .cordic_rdy(cordic_rdy),
    .in_valid(in_valid), .in_ready(in_ready), .core_en(core_en),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_idx(out_idx),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state), .dbg_pend(dbg_pend)
  );

  int errors = 0;
  int checks = 0;

  // Hand-written bit-reversed output order for a 16-point frame.
  logic [3:0] brev_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  // Scoreboard entries are {sop, eop, idx}.
  logic [5:0] obs_q[$];
  logic [5:0] exp_q[$];
  int en_cycles = 0;
  int acc_cycles = 0;
  bit saw_flush = 0;

  always @(negedge sys_clk) begin
    if (out_valid === 1'b1) obs_q.push_back({out_sop, out_eop, out_idx});
    if (core_en === 1'b1) en_cycles++;
    if (in_valid === 1'b1 && in_ready === 1'b1) acc_cycles++;
    if (dbg_state === S_FLUSH) saw_flush = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Driver: offer samples until n are accepted. gap_pct is the chance of an
  // idle cycle.
  task automatic push(input int n, input int gap_pct);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      @(negedge sys_clk);
      if (in_valid && in_ready) sent++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("push_accepts", sent, n);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output int c);
    c = 0;
    @(negedge sys_clk);
    while (dbg_state !== s && c < max) begin
      @(negedge sys_clk);
      c++;
    end
    tick();
  endtask

  task automatic check_frames(input string tag, input int nfr);
    int n;
    exp_q.delete();
    for (int i = 0; i < nfr * FL; i++)
      exp_q.push_back({(i % FL) == 0, (i % FL) == FL - 1, brev_tab[i % FL]});
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_bin"}, obs_q[i], exp_q[i]);
    obs_q.delete();
  endtask

  initial begin
    int c;
    bit bad;
    int e0, a0;

    // reset state
    in_valid = 1'b1;
    tick(); tick();
    @(negedge sys_clk);
    chk("rst_state", dbg_state, S_WAIT);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    tick();
    sys_nrst = 1'b1;

    // CORDICs not ready for 50 cycles while upstream offers data
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (in_ready !== 1'b0 || core_en !== 1'b0 || dbg_state !== S_WAIT) bad = 1;
      tick();
    end
    chk("rdy_wait_blocked", bad, 0);
    in_valid = 1'b0;
    cordic_rdy = 1'b1;
    tick();
    @(negedge sys_clk);
    chk("rdy_to_idle", dbg_state, S_IDLE);
    chk("idle_in_ready", in_ready, 1);
    tick();

    // single frame, then self-flush after FLUSH_WAIT idle cycles
    obs_q.delete();
    push(FL, 0);
    chk("run_busy", busy, 1);
    @(negedge sys_clk);
    c = 0;
    while (dbg_state !== S_FLUSH && c < 100) begin
      @(negedge sys_clk);
      c++;
    end
    chk("flush_delay", c, FW);
    tick();
    wait_state(S_IDLE, 200, c);
    chk("flush1_done", dbg_state, S_IDLE);
    check_frames("f1", 1);
    chk("f1_frame_done", frame_done, 1);
    chk("f1_busy", busy, 0);

    // async reset, then three back-to-back frames
    sys_nrst = 1'b0;
    #1;
    chk("rst2_frame_done", frame_done, 0);
    tick();
    sys_nrst = 1'b1;
    saw_flush = 0;
    push(3 * FL, 0);
    chk("b2b_no_flush", saw_flush, 0);
    wait_state(S_IDLE, 300, c);
    chk("b2b_done", dbg_state, S_IDLE);
    check_frames("b2b", 3);
    chk("b2b_frame_done", frame_done, 3);
    chk("b2b_pend", dbg_pend, 0);

    // 30% gaps: one enable per accept, same bin sequence as a gapless run
    e0 = en_cycles;
    a0 = acc_cycles;
    push(FL, 30);
    chk("gap_en_per_accept", en_cycles - e0, acc_cycles - a0);
    wait_state(S_IDLE, 300, c);
    check_frames("gap", 1);
    chk("gap_frame_done", frame_done, 4);

    // CORDIC ready drops for 5 cycles in the middle of a flush
    push(FL, 0);
    wait_state(S_FLUSH, 100, c);
    repeat (8) tick();
    chk("drop_in_flush", dbg_state, S_FLUSH);
    cordic_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (core_en !== 1'b0 || out_valid !== 1'b0 || dbg_state !== S_FLUSH) bad = 1;
      tick();
    end
    chk("drop_frozen", bad, 0);
    cordic_rdy = 1'b1;
    wait_state(S_IDLE, 300, c);
    check_frames("drop", 1);
    chk("drop_frame_done", frame_done, 5);

    // abort after 7 samples discards them
    push(7, 0);
    abort = 1'b1;
    @(negedge sys_clk);
    chk("abort_in_ready", in_ready, 0);
    tick();
    abort = 1'b0;
    @(negedge sys_clk);
    chk("abort_state", dbg_state, S_IDLE);
    chk("abort_pend", dbg_pend, 0);
    chk("abort_frame_done", frame_done, 0);
    chk("abort_no_output", obs_q.size(), 0);
    tick();
    push(FL, 0);
    wait_state(S_IDLE, 300, c);
    check_frames("post_abort", 1);
    chk("post_abort_frame_done", frame_done, 1);

    // A partial frame never flushes. Async reset mid-frame restarts cleanly.
    push(5, 0);
    repeat (40) tick();
    chk("partial_stays_run", dbg_state, S_RUN);
    sys_nrst = 1'b0;
    #1;
    chk("midrst_state", dbg_state, S_WAIT);
    chk("midrst_pend", dbg_pend, 0);
    chk("midrst_busy", busy, 0);
    tick();
    sys_nrst = 1'b1;
    push(FL, 0);
    wait_state(S_IDLE, 300, c);
    check_frames("post_rst", 1);
    chk("post_rst_frame_done", frame_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
